// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the MEM stage and its data-memory handshake.
// Imported by mem_stage and dmem_handshake.
package pipe_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_read;
  } ex_mem_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] read_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_wb_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Request/ready handshake for the MEM stage: wait-state FSM, timeout counter,
// and generation of dmem_req, the upstream stall and the error pulse.
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_op,
  input  logic [1:0] addr_lo,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       stall,
  output logic       mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aligned_op;

  assign aligned_op = mem_op & ~is_misaligned(addr_lo);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (aligned_op && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        // Ready in the same cycle the count expires still completes the access.
        if (dmem_ready)             state_d = IDLE;
        else if (cnt_q == CNT_MAX)  state_d = ABORT;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    mem_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req = aligned_op;
        mem_err  = mem_op & ~aligned_op;
      end
      WAIT:    dmem_req = aligned_op;
      ABORT:   mem_err  = 1'b1;
      default: ;
    endcase
  end

  assign stall = dmem_req & ~dmem_ready;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM and MEM/WB registers, word load/store over a
// req/ready data bus, upstream stall while an access is outstanding.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] ALUOutE,
  input  logic [WORD_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              MemReadE,
  output logic [WORD_W-1:0] ALUOutM,
  output logic [REG_W-1:0]  WriteRegM,
  output logic              RegWriteM,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [WORD_W-1:0] ResultW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              RegWriteW,
  output logic              mem_err
);

  ex_mem_t ex_mem_q;
  mem_wb_t mem_wb_q;
  logic    load_done;

  dmem_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_handshake (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_op    (ex_mem_q.mem_write | ex_mem_q.mem_read),
    .addr_lo   (ex_mem_q.alu_out[1:0]),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .stall     (StallM),
    .mem_err   (mem_err)
  );

  assign load_done = dmem_req & dmem_ready & ex_mem_q.mem_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else if (!StallM) begin
      ex_mem_q <= '{alu_out:    ALUOutE,
                    write_data: WriteDataE,
                    write_reg:  WriteRegE,
                    reg_write:  RegWriteE,
                    mem_to_reg: MemtoRegE,
                    mem_write:  MemWriteE,
                    mem_read:   MemReadE};
    end
  end

  // A stalled cycle inserts a bubble; a faulted access (misaligned or aborted)
  // and any write to $0 reach WB with the register write suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_q <= '0;
    end else if (StallM) begin
      mem_wb_q.reg_write <= 1'b0;
      mem_wb_q.write_reg <= '0;
    end else begin
      mem_wb_q.alu_out    <= ex_mem_q.alu_out;
      mem_wb_q.write_reg  <= ex_mem_q.write_reg;
      mem_wb_q.reg_write  <= ex_mem_q.reg_write & ~mem_err & (ex_mem_q.write_reg != '0);
      mem_wb_q.mem_to_reg <= ex_mem_q.mem_to_reg;
      if (load_done) mem_wb_q.read_data <= dmem_rdata;
    end
  end

  assign ALUOutM    = ex_mem_q.alu_out;
  assign WriteRegM  = ex_mem_q.write_reg;
  assign RegWriteM  = ex_mem_q.reg_write;
  assign dmem_addr  = ex_mem_q.alu_out;
  assign dmem_wdata = ex_mem_q.write_data;
  assign dmem_we    = ex_mem_q.mem_write;

  assign ResultW   = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_out;
  assign WriteRegW = mem_wb_q.write_reg;
  assign RegWriteW = mem_wb_q.reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random instructions
// against a transaction-level model of memory contents, wait states and timeout.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, MemReadE;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] ResultW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, mem_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem_m [64];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .StallM(StallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bubble();
    ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; MemReadE = 0;
  endtask

  // Issues one instruction, lets memory answer after k wait cycles, and checks
  // bus behaviour in M plus the values that arrive in W.
  task automatic run_instr(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input logic rw, input logic m2r,
                           input logic mw, input logic mr, input int k);
    logic mem_op, mis, done, abrt;
    int n, exp_stall, exp_req, exp_err;
    int obs_stall, obs_req, obs_err, bus_bad, bub_bad;
    mem_op = mw | mr;
    mis    = mem_op && (alu[1:0] != 2'b00);
    done   = mem_op && !mis && (k <= T);
    abrt   = mem_op && !mis && (k > T);
    if (!mem_op || mis) begin n = 1;     exp_stall = 0;     exp_req = 0;     exp_err = mis ? 1 : 0; end
    else if (done)      begin n = k + 1; exp_stall = k;     exp_req = k + 1; exp_err = 0; end
    else                begin n = T + 2; exp_stall = T + 1; exp_req = T + 1; exp_err = 1; end
    obs_stall = 0; obs_req = 0; obs_err = 0; bus_bad = 0; bub_bad = 0;

    ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw; MemReadE = mr;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      dmem_ready = (c == k);
      dmem_rdata = (c == k) ? mem_m[alu[7:2]] : $urandom;
      if (c < exp_stall) begin
        // Upstream keeps presenting a different instruction; it must not be taken.
        ALUOutE = $urandom; WriteDataE = $urandom; WriteRegE = 5'($urandom_range(1, 31));
        RegWriteE = 1; MemtoRegE = 0; MemWriteE = 0; MemReadE = 0;
      end else begin
        drive_bubble();
      end
      @(negedge clk);
      if (c == 0) check({tag, ".alu_m"}, ALUOutM, alu);
      if (c >= 1 && RegWriteW) bub_bad++;
      if (dmem_req) begin
        obs_req++;
        if (dmem_addr !== alu || dmem_wdata !== wd || dmem_we !== mw) bus_bad++;
      end
      if (StallM)  obs_stall++;
      if (mem_err) obs_err++;
      @(posedge clk); #1;
    end
    drive_bubble();
    dmem_ready = 0;
    if (done && mr) last_rdata = mem_m[alu[7:2]];
    if (done && mw) mem_m[alu[7:2]] = wd;
    @(negedge clk);
    check({tag, ".req_cycles"},   obs_req,   exp_req);
    check({tag, ".stall_cycles"}, obs_stall, exp_stall);
    check({tag, ".err_cycles"},   obs_err,   exp_err);
    check({tag, ".bus_unstable"}, bus_bad,   0);
    check({tag, ".w_bubbles"},    bub_bad,   0);
    check({tag, ".write_reg_w"},  WriteRegW, wr);
    check({tag, ".reg_write_w"},  RegWriteW, rw && (wr != 0) && !mis && !abrt);
    check({tag, ".result_w"},     ResultW,   m2r ? last_rdata : alu);
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    for (int i = 0; i < 64; i++) mem_m[i] = $urandom;
    mem_m[4] = 32'hDEAD_BEEF;
    last_rdata = '0;
    drive_bubble();
    dmem_ready = 0;
    dmem_rdata = '0;
    rst_n = 0;
    #1;
    check("reset.req",      dmem_req, 0);
    check("reset.stall",    StallM,   0);
    check("reset.err",      mem_err,  0);
    check("reset.alu_m",    ALUOutM,  0);
    check("reset.result_w", ResultW,  0);
    check("reset.regw_w",   RegWriteW, 0);
    #11 rst_n = 1;
    @(posedge clk); #1;

    run_instr("zw_load",   32'h10, 32'h0,    5'd8,  1, 1, 0, 1, 0);
    run_instr("st3",       32'h20, 32'h1234, 5'd0,  0, 0, 1, 0, 3);
    run_instr("ld_back",   32'h20, 32'h0,    5'd9,  1, 1, 0, 1, 1);
    run_instr("mis_load",  32'h22, 32'h0,    5'd10, 1, 1, 0, 1, 0);
    run_instr("timeout",   32'h30, 32'hBAD0, 5'd0,  0, 0, 1, 0, 99);
    run_instr("after_to",  32'h30, 32'h0,    5'd11, 1, 1, 0, 1, 0);
    run_instr("rdy_at_max",32'h34, 32'h0,    5'd12, 1, 1, 0, 1, T);
    run_instr("alu_r0",    $urandom, 32'h0,  5'd0,  1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      case (kind)
        0: run_instr("rnd_alu", $urandom, d, 5'($urandom), 1, 0, 0, 0, 0);
        1: run_instr("rnd_ld",  a, d, 5'($urandom), 1, 1, 0, 1, $urandom_range(0, T + 2));
        default: run_instr("rnd_st", a, d, 5'($urandom), 0, 0, 1, 0, $urandom_range(0, T + 2));
      endcase
    end

    // Reset while a load is waiting on memory.
    ALUOutE = 32'h40; WriteDataE = '0; WriteRegE = 5'd7;
    RegWriteE = 1; MemtoRegE = 1; MemWriteE = 0; MemReadE = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.stall_before", StallM, 1);
    #1 rst_n = 0;
    #1;
    check("rst_mid.req",       dmem_req,  0);
    check("rst_mid.stall",     StallM,    0);
    check("rst_mid.err",       mem_err,   0);
    check("rst_mid.alu_m",     ALUOutM,   0);
    check("rst_mid.result_w",  ResultW,   0);
    check("rst_mid.wreg_w",    WriteRegW, 0);
    check("rst_mid.regw_w",    RegWriteW, 0);
    drive_bubble();
    last_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    run_instr("post_rst_ld", 32'h40, 32'h0, 5'd7, 1, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
